// File: rtl/laser_point_buffer.sv
// laser_point_buffer: captures one frame of NUM_PTS (X,Y) points and serves registered random-access reads.
// Ports:
//    clk, rst          rising-edge clock, asynchronous active-high reset
//    x, y              point coordinates, sampled every edge while loading
//    solver_done       pulse in READY that re-arms loading for the next frame
//    rd_addr           read index; rd_x/rd_y return mem[rd_addr] one cycle later (0 when out of range)
//    loaded            full frame stored and readable
//    frame_cnt         completed frames, wraps modulo 256
// Optional LASER_PTBUF_BITMAP_EN adds row_sel/row_bits: a 16x16 occupancy bitmap of the frame,
// row_bits[i] = point present at (x=i, y=row_sel), registered one cycle after row_sel.
module laser_point_buffer #(
   parameter int NUM_PTS = 40,
   parameter int CW = 4,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] x,
   input  logic [CW-1:0] y,
   input  logic          solver_done,
   input  logic [AW-1:0] rd_addr,
`ifdef LASER_PTBUF_BITMAP_EN
   input  logic [CW-1:0] row_sel,
   output logic [15:0]   row_bits,
`endif
   output logic [CW-1:0] rd_x,
   output logic [CW-1:0] rd_y,
   output logic          loaded,
   output logic [7:0]    frame_cnt
);
   localparam logic [AW-1:0] LAST = AW'(NUM_PTS - 1);
   typedef enum logic {LOAD, READY} state_t;
   state_t state, state_nx;
   logic [AW-1:0] wr_ptr, wr_ptr_nx;
   logic [2*CW-1:0] mem [2**AW];
   logic last;
   always_comb begin
      last = wr_ptr == LAST;
      state_nx = state == LOAD ? (last ? READY : LOAD) : (solver_done ? LOAD : READY);
      wr_ptr_nx = state == LOAD ? (last ? '0 : wr_ptr + 1'b1) : wr_ptr;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LOAD;
         wr_ptr <= '0;
         frame_cnt <= '0;
         rd_x <= '0;
         rd_y <= '0;
      end else begin
         state <= state_nx;
         wr_ptr <= wr_ptr_nx;
         if (state == LOAD && last) frame_cnt <= frame_cnt + 8'd1;
         rd_x <= rd_addr <= LAST ? mem[rd_addr][2*CW-1:CW] : '0;
         rd_y <= rd_addr <= LAST ? mem[rd_addr][CW-1:0] : '0;
      end
   end
   assign loaded = state == READY;
   // Memory is not reset; the nonblocking write gives read-before-write on a shared index.
   always_ff @(posedge clk) begin
      if (state == LOAD) mem[wr_ptr] <= {x, y};
   end
`ifdef LASER_PTBUF_BITMAP_EN
   logic [15:0][15:0] bitmap;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bitmap <= '0;
         row_bits <= '0;
      end else begin
         if (state == READY && solver_done) bitmap <= '0;
         else if (state == LOAD) bitmap[y][x] <= 1'b1;
         row_bits <= bitmap[row_sel];
      end
   end
`endif
endmodule

// File: doc/laser_point_buffer.md
Name: laser_point_buffer

Overview:
- Input stage directly upstream of the two-circle laser solver.
- Captures one target point (X,Y on a 16x16 grid) per clock from the stimulus stream and stores a full frame of NUM_PTS points.
- Signals frame-ready, then serves random-access reads to the solver.
- Re-arms for the next frame when the solver pulses its DONE.

Parameters:
- NUM_PTS, 40, points per frame (2..63)
- CW, 4, coordinate width in bits
- AW, 6, read/write address width (2^AW >= NUM_PTS)

Ports:
- CLK  in  1  clock, rising-edge
- RST  in  1  asynchronous active-high reset
- X  in  CW  point X coordinate, sampled every cycle in LOAD
- Y  in  CW  point Y coordinate, sampled every cycle in LOAD
- SOLVER_DONE  in  1  solver result-valid pulse; ends the current frame
- RD_ADDR  in  AW  solver read index
- RD_X  out  CW  registered X of mem[RD_ADDR]
- RD_Y  out  CW  registered Y of mem[RD_ADDR]
- LOADED  out  1  full frame stored and readable
- FRAME_CNT  out  8  number of completed frames loaded, wraps 255->0

Behaviour:
- Reset is asynchronous and active-high on RST, single clock CLK.
- Reset values:
  - state=LOAD, wr_ptr=0
  - RD_X=0, RD_Y=0, LOADED=0, FRAME_CNT=0
  - memory contents not reset
- State machine has two states: LOAD and READY.
- LOAD:
  - Every rising edge writes {X,Y} to mem[wr_ptr] and increments wr_ptr.
  - The first sample is the first rising edge after RST deasserts.
  - The edge that writes index NUM_PTS-1 sets wr_ptr=0, state=READY, LOADED=1 and FRAME_CNT+1, all visible in the same cycle after that edge.
  - Exactly NUM_PTS samples per frame; there are no gaps or stalls.
- READY:
  - X/Y are ignored and memory is frozen.
  - SOLVER_DONE high at an edge sets state=LOAD and LOADED=0 at that edge.
  - The first point of the next frame is sampled on the following edge.
- SOLVER_DONE while in LOAD is ignored; it neither restarts nor aborts the load.
- Read port:
  - RD_X/RD_Y update every edge, regardless of state, from mem[RD_ADDR]. Latency is 1 cycle.
  - RD_ADDR >= NUM_PTS returns RD_X=0, RD_Y=0.
  - Reads during LOAD return current memory contents: new data for indices already written this frame, previous frame's data otherwise. The solver must only trust reads while LOADED=1.
- Read of the index being written in the same LOAD edge returns the old value (read-before-write).
- FRAME_CNT wraps modulo 256 with no saturation.
- RST asserted mid-load or mid-READY:
  - Immediate return to reset values.
  - The partial frame is discarded.
  - Loading restarts at index 0 after deassertion.
- Coordinates are unsigned 0..15 and stored verbatim. Duplicate points are stored as separate entries.

Optional Feature:
- Macro: LASER_PTBUF_BITMAP_EN.
- When defined:
  - Adds input ROW_SEL (CW) and output ROW_BITS (16).
  - Maintains a 16x16 occupancy bitmap. The bit at (Y,X) is set when a point is written in LOAD.
  - The whole bitmap clears on RST and on the READY->LOAD transition.
  - ROW_BITS is registered with 1-cycle latency from ROW_SEL; bit i = point present at (X=i, Y=ROW_SEL).
  - Duplicates leave the bit set once.
- When undefined: neither port exists and no bitmap logic is present; all other behaviour is identical.

Test Plan:
- Basic load and read:
  - Stimulus: release RST, drive X=i%16, Y=(3*i)%16 for i=0..39.
  - Required: LOADED=1 and FRAME_CNT=1 the cycle after the 40th edge. RD_ADDR=7 gives RD_X=7, RD_Y=5 one cycle later. RD_ADDR=39 gives 7,5. RD_ADDR=45 gives 0,0.
- Frame turnover:
  - Stimulus: in READY, pulse SOLVER_DONE for 1 cycle, then stream 40 points all (15,15).
  - Required: LOADED=0 the cycle after DONE. The first new point lands at index 0. After 40 edges LOADED=1, FRAME_CNT=2, and every index reads 15,15.
- Ignored inputs:
  - Stimulus: during READY, toggle X/Y randomly for 100 cycles. Separately, pulse SOLVER_DONE at load index 20.
  - Required: memory unchanged during READY. The load completes normally at index 39 and FRAME_CNT increments by exactly 1.
- Reset mid-load:
  - Stimulus: assert RST asynchronously after 25 points, then release and stream 40 points X=1,Y=2.
  - Required: outputs go to 0 immediately. LOADED rises after exactly 40 further edges, FRAME_CNT=1, and all entries read 1,2.
- FRAME_CNT wrap:
  - Stimulus: run 256 frames.
  - Required: FRAME_CNT=0 after the 256th frame, 1 after the 257th.
- Bitmap (with LASER_PTBUF_BITMAP_EN):
  - Stimulus: frame containing (4,10) twice and (11,12).
  - Required: ROW_SEL=10 gives ROW_BITS=16'h0010; ROW_SEL=12 gives 16'h0800. After SOLVER_DONE, all rows read 0.
